// File: rtl/sumador_pkg.sv
// Shared constants and types for the registered 8-bit adder.
// Contents:
//   SUM_WIDTH - default operand width
//   operand_t - one operand
//   sum_t     - full-precision sum; the top bit is the carry-out
package sumador_pkg;

  localparam int unsigned SUM_WIDTH = 8;

  typedef logic [SUM_WIDTH-1:0] operand_t;
  typedef logic [SUM_WIDTH:0]   sum_t;

endpackage

// File: rtl/sumador_8bits_sync_full_adder.sv
// One-bit combinational full adder. It is one stage of the ripple chain.
// Ports:
//   a, b - operand bits
//   cin  - carry in from the previous stage
//   s    - sum bit
//   cout - carry out to the next stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_8bits_sync.sv
// Registered ripple-carry adder: D8 = A8 + B8 + Carry_i, one cycle after valid_i.
// Optional feature: define SUMADOR_OVF_EN to add the registered two's-complement
// overflow flag ovf_o.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   A8, B8  - unsigned operands
//   Carry_i - carry-in to stage 0
//   valid_i - operands valid this cycle
//   D8      - registered sum; D8[WIDTH] is the carry-out
//   valid_o - D8 holds a new result this cycle
//   ovf_o   - signed overflow of the WIDTH-bit result (SUMADOR_OVF_EN only)
module sumador_8bits_sync
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = SUM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A8,
  input  logic [WIDTH-1:0] B8,
  input  logic             Carry_i,
  input  logic             valid_i,
  output logic [WIDTH:0]   D8,
  output logic             valid_o
`ifdef SUMADOR_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   d8_d, d8_q;
  logic             valid_q;

  assign carry[0] = Carry_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (A8[i]),
      .b    (B8[i]),
      .cin  (carry[i]),
      .s    (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  assign d8_d = {carry[WIDTH], sum_bits};

  // valid_o tracks valid_i directly. D8 only loads on valid and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d8_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        d8_q <= d8_d;
      end
    end
  end

  assign D8      = d8_q;
  assign valid_o = valid_q;

`ifdef SUMADOR_OVF_EN
  logic ovf_d, ovf_q;

  // The operands share a sign, but the result sign differs from it.
  assign ovf_d = (A8[WIDTH-1] == B8[WIDTH-1]) && (sum_bits[WIDTH-1] != A8[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (valid_i) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_8bits_sync.sv
// Directed and random self-checking bench for sumador_8bits_sync.
module tb_sumador_8bits_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       carry_in;
  logic       valid_in;
  logic [8:0] d8;
  logic       valid_out;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  sumador_8bits_sync #(
    .WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A8      (a8),
    .B8      (b8),
    .Carry_i (carry_in),
    .valid_i (valid_in),
    .D8      (d8),
    .valid_o (valid_out)
`ifdef SUMADOR_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

`ifndef SUMADOR_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SUMADOR_OVF_EN
    chk(tag, {8'h00, ovf}, {8'h00, exp});
`endif
  endtask

  // Drive operands at negedge, sample the registered result just after the next posedge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic v);
    @(negedge clk);
    a8       = a;
    b8       = b;
    carry_in = c;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  logic [8:0] exp_d8;
  logic       exp_ovf;
  logic [7:0] ra, rb;
  logic       rc, rv;
  logic [8:0] rs;

  initial begin
    rst_n    = 1'b0;
    a8       = 8'h00;
    b8       = 8'h00;
    carry_in = 1'b0;
    valid_in = 1'b0;
    #2;
    chk("reset_d8", d8, 9'h000);
    chk("reset_valid", {8'h00, valid_out}, 9'h000);
    chk_ovf("reset_ovf", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(8'h0F, 8'h0F, 1'b0, 1'b1);
    chk("d8_0f_0f", d8, 9'h01E);
    chk("valid_0f_0f", {8'h00, valid_out}, 9'h001);

    // Back-to-back operands, one result per cycle.
    step(8'h33, 8'h33, 1'b0, 1'b1);
    chk("d8_33_33", d8, 9'h066);
    chk("valid_33_33", {8'h00, valid_out}, 9'h001);
    chk_ovf("ovf_33_33", 1'b0);
    step(8'h77, 8'h77, 1'b0, 1'b1);
    chk("d8_77_77", d8, 9'h0EE);
    chk("valid_77_77", {8'h00, valid_out}, 9'h001);
    chk_ovf("ovf_77_77", 1'b1);

    // Full carry ripple.
    step(8'hFF, 8'hFF, 1'b0, 1'b1);
    chk("d8_ff_ff", d8, 9'h1FE);
    chk_ovf("ovf_ff_ff", 1'b0);
    step(8'hFF, 8'h00, 1'b1, 1'b1);
    chk("d8_ff_00_c", d8, 9'h100);
    chk_ovf("ovf_ff_00_c", 1'b0);
    step(8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("d8_max", d8, 9'h1FF);
    step(8'h80, 8'h80, 1'b0, 1'b1);
    chk("d8_80_80", d8, 9'h100);
    chk_ovf("ovf_80_80", 1'b1);

    // Hold: D8 keeps 0x100 while inputs change with valid_i low.
    step(8'h12, 8'h34, 1'b1, 1'b0);
    chk("hold1_d8", d8, 9'h100);
    chk("hold1_valid", {8'h00, valid_out}, 9'h000);
    chk_ovf("hold1_ovf", 1'b1);
    step(8'hAA, 8'h55, 1'b0, 1'b0);
    chk("hold2_d8", d8, 9'h100);
    chk("hold2_valid", {8'h00, valid_out}, 9'h000);
    step(8'h01, 8'hFE, 1'b1, 1'b0);
    chk("hold3_d8", d8, 9'h100);
    chk("hold3_valid", {8'h00, valid_out}, 9'h000);

    // Asynchronous reset mid-stream, with a pending valid operand set.
    step(8'h77, 8'h77, 1'b0, 1'b1);
    chk("pre_rst_d8", d8, 9'h0EE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d8", d8, 9'h000);
    chk("async_rst_valid", {8'h00, valid_out}, 9'h000);
    chk_ovf("async_rst_ovf", 1'b0);
    @(posedge clk);
    #1;
    chk("in_rst_d8", d8, 9'h000);
    chk("in_rst_valid", {8'h00, valid_out}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 8'h02, 1'b1, 1'b1);
    chk("post_rst_d8", d8, 9'h004);
    chk("post_rst_valid", {8'h00, valid_out}, 9'h001);

    // Random vectors against the reference model A8+B8+Carry_i, with hold tracking.
    exp_d8  = 9'h004;
    exp_ovf = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      rs = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      if (rv) begin
        exp_d8  = rs;
        exp_ovf = (ra[7] == rb[7]) && (rs[7] != ra[7]);
      end
      step(ra, rb, rc, rv);
      chk("rand_d8", d8, exp_d8);
      chk("rand_valid", {8'h00, valid_out}, {8'h00, rv});
      chk_ovf("rand_ovf", exp_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
